delta_calc_scheduler: RTL

Round-robin scheduler that shares one `calculate_delta` instance between NUM_REQ steering-wheel requesters in the swerve PWM control path. Each requester posts a target/current angle pair. The scheduler grants one requester at a time, latches its operands, and sequences the `enable_calc` / `calc_updated` handshake. It returns the shortest-path direction and delta with a per-requester done pulse, and a timeout error if the datapath never answers.

---
 rtl/delta_sched_pkg.sv | 38 +++
 rtl/calculate_delta.sv | 68 ++++++
 rtl/delta_calc_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/delta_sched_pkg.sv
// Shared types and helpers for the delta_calc_scheduler slice: angle width,
// scheduler states and the round-robin pick.
package delta_sched_pkg;

    localparam int ANGLE_W   = 12;
    localparam int HALF_TURN = 2048;
    localparam int MAX_REQ   = 8;
    localparam int GRANT_W   = 3;
    localparam int CNT_W     = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        RELEASE = 2'd2
    } sched_state_t;

    // First set bit at or after last+1, wrapping modulo num_req; returns last when none is set.
    function automatic logic [GRANT_W-1:0] rr_next(
        input logic [MAX_REQ-1:0] req,
        input logic [GRANT_W-1:0] last,
        input int                 num_req
    );
        logic [GRANT_W-1:0] pick;
        logic               found;
        int                 idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = (int'(last) + i) % num_req;
            if (!found && (i <= num_req) && req[idx[GRANT_W-1:0]]) begin
                pick  = idx[GRANT_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/calculate_delta.sv
// Shortest-path angle delta datapath. Answers once per enable_calc assertion
// after LATENCY enabled cycles and re-arms when enable_calc drops.
module calculate_delta
    import delta_sched_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable_calc,
    input  logic [ANGLE_W-1:0] target_angle,
    input  logic [ANGLE_W-1:0] current_angle,
    output logic               dir_shortest,
    output logic [ANGLE_W-1:0] delta_angle,
    output logic               calc_updated
);

    logic [CNT_W-1:0]   lat_q, lat_d;
    logic               armed_q, armed_d;
    logic               upd_q, upd_d;
    logic               dir_q, dir_d;
    logic [ANGLE_W-1:0] delta_q, delta_d;
    logic [ANGLE_W-1:0] cw_dist;

    always_comb begin
        // Modulo-4096 wrap of the subtraction gives the clockwise distance directly.
        cw_dist = target_angle - current_angle;
        lat_d   = lat_q;
        armed_d = armed_q;
        upd_d   = 1'b0;
        dir_d   = dir_q;
        delta_d = delta_q;
        if (!enable_calc) begin
            lat_d   = '0;
            armed_d = 1'b1;
        end else if (armed_q) begin
            if (lat_q == CNT_W'(LATENCY - 1)) begin
                upd_d   = 1'b1;
                armed_d = 1'b0;
                dir_d   = (cw_dist <= ANGLE_W'(HALF_TURN));
                delta_d = dir_d ? cw_dist : (ANGLE_W'(0) - cw_dist);
            end else begin
                lat_d = lat_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_q   <= '0;
            armed_q <= 1'b1;
            upd_q   <= 1'b0;
            dir_q   <= 1'b0;
            delta_q <= '0;
        end else begin
            lat_q   <= lat_d;
            armed_q <= armed_d;
            upd_q   <= upd_d;
            dir_q   <= dir_d;
            delta_q <= delta_d;
        end
    end

    assign dir_shortest = dir_q;
    assign delta_angle  = delta_q;
    assign calc_updated = upd_q;

endmodule

// File: rtl/delta_calc_scheduler.sv
// Round-robin arbiter sharing one calculate_delta between NUM_REQ requesters,
// with per-requester done/err pulses and a bounded wait on the datapath.
module delta_calc_scheduler
    import delta_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT      = 255,
    parameter int CALC_LATENCY = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [ANGLE_W*NUM_REQ-1:0] target_angle_bus,
    input  logic [ANGLE_W*NUM_REQ-1:0] current_angle_bus,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         err,
    output logic                       dir_out,
    output logic [ANGLE_W-1:0]         delta_out,
    output logic [GRANT_W-1:0]         grant_id,
    output logic                       busy
);

    sched_state_t       state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] last_grant_q, last_grant_d;
    logic [ANGLE_W-1:0] target_q, target_d;
    logic [ANGLE_W-1:0] current_q, current_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic               dir_q, dir_d;
    logic [ANGLE_W-1:0] delta_q, delta_d;

    logic [ANGLE_W-1:0] target_arr  [NUM_REQ];
    logic [ANGLE_W-1:0] current_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant_oh;
    logic [MAX_REQ-1:0] req_ext;
    logic [GRANT_W-1:0] rr_pick;
    logic [ANGLE_W-1:0] target_sel, current_sel;
    logic               enable_calc;
    logic               calc_dir;
    logic [ANGLE_W-1:0] calc_delta;
    logic               calc_updated;
    logic               timed_out;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign target_arr[gi]  = target_angle_bus[gi*ANGLE_W +: ANGLE_W];
            assign current_arr[gi] = current_angle_bus[gi*ANGLE_W +: ANGLE_W];
            assign grant_oh[gi]    = (grant_q == GRANT_W'(gi));
        end
    endgenerate

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        rr_pick              = rr_next(req_ext, last_grant_q, NUM_REQ);
        target_sel           = '0;
        current_sel          = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_pick == GRANT_W'(i)) begin
                target_sel  = target_arr[i];
                current_sel = current_arr[i];
            end
        end
    end

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = CALC;
            CALC:    if (calc_updated || timed_out) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result and bookkeeping registers; a late calc_updated takes priority over the timeout.
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        target_d     = target_q;
        current_d    = current_q;
        cnt_d        = cnt_q;
        done_d       = '0;
        err_d        = '0;
        dir_d        = dir_q;
        delta_d      = delta_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d   = rr_pick;
                    target_d  = target_sel;
                    current_d = current_sel;
                    cnt_d     = '0;
                end
            end
            CALC: begin
                if (calc_updated) begin
                    done_d  = grant_oh;
                    dir_d   = calc_dir;
                    delta_d = calc_delta;
                end else if (timed_out) begin
                    err_d = grant_oh;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: last_grant_d = grant_q;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_q      <= '0;
            last_grant_q <= GRANT_W'(NUM_REQ - 1);
            target_q     <= '0;
            current_q    <= '0;
            cnt_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
            dir_q        <= 1'b0;
            delta_q      <= '0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            target_q     <= target_d;
            current_q    <= current_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            dir_q        <= dir_d;
            delta_q      <= delta_d;
        end
    end

    always_comb begin
        busy        = (state_q != IDLE);
        enable_calc = (state_q == CALC);
        done        = done_q;
        err         = err_q;
        dir_out     = dir_q;
        delta_out   = delta_q;
        grant_id    = grant_q;
    end

    calculate_delta #(
        .LATENCY (CALC_LATENCY)
    ) u_calc (
        .clock         (clock),
        .reset_n       (~reset),
        .enable_calc   (enable_calc),
        .target_angle  (target_q),
        .current_angle (current_q),
        .dir_shortest  (calc_dir),
        .delta_angle   (calc_delta),
        .calc_updated  (calc_updated)
    );

endmodule
